// File: rtl/exec_unit_seq_pkg.sv
// Shared types and constants for the execution unit: operation encoding,
// FSM state type and default widths.
package exec_unit_seq_pkg;

    localparam int PKG_DATA_WIDTH   = 32;
    localparam int PKG_ADDR_WIDTH   = 16;
    localparam int EXEC_IMM_WIDTH   = 6;
    localparam int EXEC_MEM_TIMEOUT = 16;

    // Encodings 13..15 are unused and reported as illegal by the ALU.
    typedef enum logic [3:0] {
        FUNC_ADD   = 4'd0,
        FUNC_SUB   = 4'd1,
        FUNC_ADDI  = 4'd2,
        FUNC_AND   = 4'd3,
        FUNC_OR    = 4'd4,
        FUNC_XOR   = 4'd5,
        FUNC_NOT   = 4'd6,
        FUNC_SLL   = 4'd7,
        FUNC_SLR   = 4'd8,
        FUNC_SLLI  = 4'd9,
        FUNC_SLRI  = 4'd10,
        FUNC_LOAD  = 4'd11,
        FUNC_STORE = 4'd12
    } func_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } exec_state_t;

    function automatic logic isMemOp(input func_t f);
        return (f == FUNC_LOAD) || (f == FUNC_STORE);
    endfunction

endpackage

// File: rtl/exec_unit_seq_if.sv
// Bundles the issue handshake, result channel and DMEM port of the execution unit.
// The slave modport is the unit; the master modport is the issuing/memory side.
interface exec_unit_seq_if
    import exec_unit_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = PKG_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = PKG_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = DATA_WIDTH,
    parameter int IMM_WIDTH      = EXEC_IMM_WIDTH
) ();

    logic                      valid_i;
    logic                      ready_o;
    func_t                     func_i;
    logic [DATA_WIDTH-1:0]     rs1_data_i;
    logic [DATA_WIDTH-1:0]     rs2_data_i;
    logic [IMM_WIDTH-1:0]      imm_i;
    logic                      valid_o;
    logic [DATA_WIDTH-1:0]     rd_data_o;
    logic                      err_o;
    logic                      dmem_req_o;
    logic [MEM_ADDR_WIDTH-1:0] dmem_addr_o;
    logic                      dmem_we_o;
    logic [MEM_DATA_WIDTH-1:0] dmem_wdata_o;
    logic [MEM_DATA_WIDTH-1:0] dmem_rdata_i;
    logic                      dmem_ack_i;

    modport slave (
        input  valid_i, func_i, rs1_data_i, rs2_data_i, imm_i,
        input  dmem_rdata_i, dmem_ack_i,
        output ready_o, valid_o, rd_data_o, err_o,
        output dmem_req_o, dmem_addr_o, dmem_we_o, dmem_wdata_o
    );

    modport master (
        output valid_i, func_i, rs1_data_i, rs2_data_i, imm_i,
        output dmem_rdata_i, dmem_ack_i,
        input  ready_o, valid_o, rd_data_o, err_o,
        input  dmem_req_o, dmem_addr_o, dmem_we_o, dmem_wdata_o
    );

endinterface

// File: rtl/exec_unit_seq_alu.sv
// Combinational ALU for the execution unit: arithmetic, bitwise and shift ops
// with a sign-extended immediate; flags encodings it does not implement.
module exec_alu
    import exec_unit_seq_pkg::*;
#(
    parameter int DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int IMM_WIDTH  = EXEC_IMM_WIDTH
) (
    input  func_t                 i_func,
    input  logic [DATA_WIDTH-1:0] i_rs1,
    input  logic [DATA_WIDTH-1:0] i_rs2,
    input  logic [IMM_WIDTH-1:0]  i_imm,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_illegal
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] w_immExt;
    logic [SHW-1:0]        w_shRs2;
    logic [SHW-1:0]        w_shImm;

    assign w_immExt = {{(DATA_WIDTH-IMM_WIDTH){i_imm[IMM_WIDTH-1]}}, i_imm};
    assign w_shRs2  = i_rs2[SHW-1:0];
    assign w_shImm  = w_immExt[SHW-1:0];

    // Memory ops are legal here but produce no ALU result; the FSM handles them.
    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_func)
            FUNC_ADD:   o_result = i_rs1 + i_rs2;
            FUNC_SUB:   o_result = i_rs1 - i_rs2;
            FUNC_ADDI:  o_result = i_rs1 + w_immExt;
            FUNC_AND:   o_result = i_rs1 & i_rs2;
            FUNC_OR:    o_result = i_rs1 | i_rs2;
            FUNC_XOR:   o_result = i_rs1 ^ i_rs2;
            FUNC_NOT:   o_result = ~i_rs1;
            FUNC_SLL:   o_result = i_rs1 << w_shRs2;
            FUNC_SLR:   o_result = i_rs1 >> w_shRs2;
            FUNC_SLLI:  o_result = i_rs1 << w_shImm;
            FUNC_SLRI:  o_result = i_rs1 >> w_shImm;
            FUNC_LOAD,
            FUNC_STORE: o_result = '0;
            default:    o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_unit_seq.sv
// Registered, handshaked execution unit: single-cycle ALU ops plus LOAD/STORE
// through a req/ack data-memory port with an optional ack timeout.
module exec_unit_seq
    import exec_unit_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = PKG_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = PKG_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = DATA_WIDTH,
    parameter int IMM_WIDTH      = EXEC_IMM_WIDTH,
    parameter int MEM_TIMEOUT    = EXEC_MEM_TIMEOUT
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    exec_unit_seq_if.slave bus
);

    localparam int          CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    exec_state_t               r_state;
    exec_state_t               w_nextState;
    logic [CNT_W-1:0]          r_timeoutCnt;
    logic [DATA_WIDTH-1:0]     r_rdData;
    logic                      r_valid;
    logic                      r_err;
    logic                      r_req;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic                      r_we;
    logic [MEM_DATA_WIDTH-1:0] r_wdata;

    logic                      w_ready;
    logic                      w_accept;
    logic                      w_memOp;
    logic                      w_timeout;
    logic [DATA_WIDTH-1:0]     w_aluResult;
    logic                      w_aluIllegal;

    exec_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH)
    ) u_alu (
        .i_func    (bus.func_i),
        .i_rs1     (bus.rs1_data_i),
        .i_rs2     (bus.rs2_data_i),
        .i_imm     (bus.imm_i),
        .o_result  (w_aluResult),
        .o_illegal (w_aluIllegal)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_accept && w_memOp) w_nextState = MEM_WAIT;
            MEM_WAIT: if (bus.dmem_ack_i || w_timeout) w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // An ack arriving in the last counted cycle wins, so the timeout is masked by ack.
    always_comb begin
        w_ready   = (r_state == IDLE);
        w_accept  = bus.valid_i && w_ready;
        w_memOp   = isMemOp(bus.func_i);
        w_timeout = (MEM_TIMEOUT != 0) && (r_state == MEM_WAIT) &&
                    (r_timeoutCnt == CNT_W'(TO_LAST)) && !bus.dmem_ack_i;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_timeoutCnt <= '0;
            r_rdData     <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_memOp) begin
                            r_req        <= 1'b1;
                            r_addr       <= MEM_ADDR_WIDTH'(bus.rs1_data_i);
                            r_we         <= (bus.func_i == FUNC_STORE);
                            r_wdata      <= MEM_DATA_WIDTH'(bus.rs2_data_i);
                            r_timeoutCnt <= '0;
                        end else begin
                            r_rdData <= w_aluResult;
                            r_valid  <= 1'b1;
                            r_err    <= w_aluIllegal;
                        end
                    end
                end
                MEM_WAIT: begin
                    // Stores leave rd_data_o untouched on both ack and timeout.
                    if (bus.dmem_ack_i) begin
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        if (!r_we) r_rdData <= DATA_WIDTH'(bus.dmem_rdata_i);
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_err   <= 1'b1;
                        if (!r_we) r_rdData <= '0;
                    end else begin
                        r_timeoutCnt <= r_timeoutCnt + 1'b1;
                    end
                end
                default: r_req <= 1'b0;
            endcase
        end
    end

    assign bus.ready_o      = w_ready;
    assign bus.valid_o      = r_valid;
    assign bus.rd_data_o    = r_rdData;
    assign bus.err_o        = r_err;
    assign bus.dmem_req_o   = r_req;
    assign bus.dmem_addr_o  = r_addr;
    assign bus.dmem_we_o    = r_we;
    assign bus.dmem_wdata_o = r_wdata;

endmodule
